booth_mult_seq: RTL and testbench

- Sequential radix-2 Booth multiplier for the datapath execute stage.
- Consumes the arithmetic-right-shift primitive: one Booth add/sub plus an arithmetic shift right by 1 per clock.
- Multiplies two signed WIDTH-bit operands into a signed 2*WIDTH-bit product over WIDTH iterations, using a start/busy/done handshake.
- Sits beside the ALU. The control unit issues start and stalls on busy.

---
 rtl/booth_mult_seq_pkg.sv | 15 +
 rtl/booth_mult_seq_if.sv | 13 +
 rtl/booth_mult_seq_step.sv | 21 ++
 rtl/booth_mult_seq.sv | 87 ++++++++
 tb/tb_booth_mult_seq.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/booth_mult_seq_pkg.sv
// Shared types for the sequential Booth multiplier: FSM state encoding and
// the iteration-counter width.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam int DEF_WIDTH = 16;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

  // Counter must represent 0..width inclusive
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/busy/done handshake and operand/product bus between the control
// unit (master) and the multiplier (slave).
interface booth_mult_seq_if #(parameter int WIDTH = 16);
  logic                   start;
  logic [WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]       mplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     prod;

  modport master (output start, mcand, mplier, input busy, done, prod);
  modport slave  (input start, mcand, mplier, output busy, done, prod);
endinterface

// File: rtl/booth_mult_seq_step.sv
// One radix-2 Booth iteration: add/sub/none on the upper field selected by
// P[1:0], followed by an arithmetic right shift of the whole register.
module booth_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH+1:0] p_i,
  input  logic [WIDTH:0]     mcand_i,
  output logic [2*WIDTH+1:0] p_o
);
  logic [WIDTH:0] u, u_n;

  always_comb begin
    u = p_i[2*WIDTH+1:WIDTH+1];
    case (p_i[1:0])
      2'b01:   u_n = u + mcand_i;
      2'b10:   u_n = u - mcand_i;
      default: u_n = u;
    endcase
    p_o = {u_n[WIDTH], u_n, p_i[WIDTH:1]};
  end
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed WIDTH x WIDTH Booth multiplier: FSM, iteration counter,
// operand latch and product register around a single booth_step.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic             clk,
  input logic             rst,
  booth_mult_seq_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2*WIDTH + 2;

  state_e              state_q, state_d;
  logic [PW-1:0]       p_q, p_d, p_step;
  logic [WIDTH:0]      mc_q, mc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;
  logic                load, last, busy, done;

  // start is only honoured when no operation is in flight
  assign load = bus.start && (state_q == IDLE || state_q == DONE);
  assign last = (state_q == CALC) && (cnt_q == CW'(WIDTH-1));

  booth_step #(.WIDTH(WIDTH)) u_step (
    .p_i     (p_q),
    .mcand_i (mc_q),
    .p_o     (p_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    state_d = load ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  always_comb begin
    p_d    = p_q;
    mc_d   = mc_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (load) begin
      p_d   = {{(WIDTH+1){1'b0}}, bus.mplier, 1'b0};
      mc_d  = {bus.mcand[WIDTH-1], bus.mcand};
      cnt_d = '0;
    end else if (state_q == CALC) begin
      p_d   = p_step;
      cnt_d = cnt_q + CW'(1);
      // Product only becomes visible once the last iteration lands
      if (last) prod_d = p_step[2*WIDTH:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      mc_q   <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      p_q    <= p_d;
      mc_q   <= mc_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.prod = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed + random checks of booth_mult_seq with a product scoreboard
// popped on each done pulse.
module tb_booth_mult_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   fails  = 0;
  logic [2*W-1:0] sb[$];

  booth_mult_seq_if #(.WIDTH(W)) bus ();

  booth_mult_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a,
                                             input logic signed [W-1:0] b);
    logic signed [2*W-1:0] x, y;
    x = a;
    y = b;
    return x * y;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) chk("spurious_done", 64'(bus.done), 64'd0);
      else                chk("prod", 64'(bus.prod), 64'(sb.pop_front()));
    end
  end

  // Called on a negedge with the DUT able to accept; returns on the done negedge
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp);
    int k, n;
    bit bok;
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    sb.push_back(exp);
    k = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    bok = 1'b1;
    while (!bus.done && n < 40) begin
      if (!bus.busy) bok = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("latency", 64'(cyc - k), 64'd16);
    chk("busy_cycles", 64'(n), 64'd16);
    chk("busy_held", 64'(bok), 64'd1);
    chk("busy_low_at_done", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int k, n;
    logic [W-1:0] a, b;
    rst = 1'b1;
    bus.start  = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_prod", 64'(bus.prod), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_one(16'd3, 16'd5, 32'h0000_000F);
    @(negedge clk); run_one(16'hFFF9, 16'd6, 32'hFFFF_FFD6);
    @(negedge clk); run_one(16'd6, 16'hFFF9, 32'hFFFF_FFD6);
    @(negedge clk); run_one(16'h8000, 16'h8000, 32'h4000_0000);
    @(negedge clk); run_one(16'h7FFF, 16'h8000, 32'hC000_8000);
    @(negedge clk); run_one(16'h0000, 16'hFFFF, 32'h0000_0000);

    // start held through CALC with changed operands must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 16'd2; bus.mplier = 16'd3;
    sb.push_back(32'd6);
    k = cyc + 1;
    @(negedge clk);
    bus.mcand = 16'd4; bus.mplier = 16'd4;
    chk("ign_busy", 64'(bus.busy), 64'd1);
    n = 0;
    while (!bus.done && n < 40) begin n++; @(negedge clk); end
    chk("ign_latency", 64'(cyc - k), 64'd16);
    sb.push_back(32'd16);
    k = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("single_done", 64'(bus.done), 64'd0);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    n = 0;
    while (!bus.done && n < 40) begin n++; @(negedge clk); end
    chk("b2b_latency", 64'(cyc - k), 64'd16);

    // reset mid-calculation aborts with no done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 16'd100; bus.mplier = 16'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_prod", 64'(bus.prod), 64'd0);
    rst = 1'b0;
    n = 0;
    repeat (30) begin @(negedge clk); if (bus.done) n++; end
    chk("abort_no_done", 64'(n), 64'd0);
    run_one(16'd100, 16'd100, 32'h0000_2710);

    // random sweep alternating done-to-start gaps of 0 and 1 cycles
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 2 == 1) @(negedge clk);
      run_one(a, b, ref_mul(a, b));
    end

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
